// File: rtl/banco_registro_np.sv
// Parametrised register bank: N_LECT registered read ports, one write port and a
// one-address-per-cycle clear sweep. Define BANCO_BYPASS_EN for write-first reads.
module banco_registro_np #(
  parameter int                     BIT_ADDR  = 3,
  parameter int                     BIT_DATO  = 4,
  parameter int                     N_LECT    = 2,
  parameter logic [BIT_DATO-1:0]    CLEAR_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_LECT*BIT_ADDR-1:0]   addrR,
  output logic [N_LECT*BIT_DATO-1:0]   datOutR,
  input  logic [BIT_ADDR-1:0]          addrW,
  input  logic [BIT_DATO-1:0]          datW,
  input  logic                         RegWrite,
  input  logic                         clr,
  output logic                         busy,
  output logic                         wr_drop
);

  localparam int DEPTH = 1 << BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST_ADDR = BIT_ADDR'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              stateReg, stateNext;
  logic [BIT_ADDR-1:0] cntReg, cntNext;
  logic                wrDropReg, wrDropNext;
  logic                wrEn;
  logic [BIT_DATO-1:0] mem [DEPTH];
  logic [BIT_DATO-1:0] rdReg [N_LECT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      wrDropReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      wrDropReg <= wrDropNext;
    end
  end

  // A write arriving together with clr is still accepted; the sweep starts next cycle.
  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    wrDropNext = 1'b0;
    wrEn       = 1'b0;
    case (stateReg)
      IDLE: begin
        wrEn = RegWrite;
        if (clr) begin
          stateNext = CLEAR;
          cntNext   = '0;
        end
      end
      CLEAR: begin
        cntNext    = cntReg + 1'b1;
        wrDropNext = RegWrite;
        if (cntReg == LAST_ADDR) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy    = (stateReg == CLEAR);
  assign wr_drop = wrDropReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CLEAR_VAL;
      end
    end else if (stateReg == CLEAR) begin
      mem[cntReg] <= CLEAR_VAL;
    end else if (wrEn) begin
      mem[addrW] <= datW;
    end
  end

  generate
    for (genvar gi = 0; gi < N_LECT; gi++) begin : g_rd
      logic [BIT_ADDR-1:0] rdAddr;
      assign rdAddr = addrR[gi*BIT_ADDR +: BIT_ADDR];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdReg[gi] <= CLEAR_VAL;
        end else begin
`ifdef BANCO_BYPASS_EN
          // Only accepted port writes forward; sweep writes never do.
          if (wrEn && (rdAddr == addrW)) begin
            rdReg[gi] <= datW;
          end else begin
            rdReg[gi] <= mem[rdAddr];
          end
`else
          rdReg[gi] <= mem[rdAddr];
`endif
        end
      end

      assign datOutR[gi*BIT_DATO +: BIT_DATO] = rdReg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_banco_registro_np.sv
// Directed self-checking bench for banco_registro_np (BIT_ADDR=3, BIT_DATO=4, N_LECT=2),
// valid with or without BANCO_BYPASS_EN.
module tb_banco_registro_np;

  logic       clk;
  logic       rst;
  logic [5:0] addrR;
  logic [7:0] datOutR;
  logic [2:0] addrW;
  logic [3:0] datW;
  logic       RegWrite;
  logic       clr;
  logic       busy;
  logic       wr_drop;

  int nTests = 0;
  int nFail  = 0;

  banco_registro_np #(
    .BIT_ADDR (3),
    .BIT_DATO (4),
    .N_LECT   (2),
    .CLEAR_VAL(4'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addrR   (addrR),
    .datOutR (datOutR),
    .addrW   (addrW),
    .datW    (datW),
    .RegWrite(RegWrite),
    .clr     (clr),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    addrR = {a1, a0};
  endtask

  task automatic write_word(input logic [2:0] a, input logic [3:0] d);
    addrW    = a;
    datW     = d;
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
  endtask

  logic [3:0] expHaz;
  logic [3:0] expSim;

  initial begin
    rst = 1'b1; addrR = '0; addrW = '0; datW = '0; RegWrite = 1'b0; clr = 1'b0;

    // Reset values before any clock edge
    #2;
    check_val("rst_rd0", 32'(datOutR[3:0]), 32'h0);
    check_val("rst_rd1", 32'(datOutR[7:4]), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_wrdrop", 32'(wr_drop), 32'h0);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      set_rd(3'(i), 3'(i + 4));
      tick();
      check_val($sformatf("rst_mem%0d", i), 32'(datOutR[3:0]), 32'h0);
      check_val($sformatf("rst_mem%0d", i + 4), 32'(datOutR[7:4]), 32'h0);
    end

    // Write then read back pairwise
    for (int j = 0; j < 8; j++) write_word(3'(j), 4'(j));
    for (int i = 0; i < 4; i++) begin
      set_rd(3'(i), 3'(i + 4));
      tick();
      check_val($sformatf("wr_rd0_a%0d", i), 32'(datOutR[3:0]), 32'(i));
      check_val($sformatf("wr_rd1_a%0d", i + 4), 32'(datOutR[7:4]), 32'(i + 4));
    end

    // Same-edge write/read to address 5
`ifdef BANCO_BYPASS_EN
    expHaz = 4'h9;
`else
    expHaz = 4'h5;
`endif
    set_rd(3'd5, 3'd0);
    write_word(3'd5, 4'h9);
    check_val("haz_same_edge", 32'(datOutR[3:0]), 32'(expHaz));
    tick();
    check_val("haz_next_edge", 32'(datOutR[3:0]), 32'h9);

    // Clear sweep with a rejected write to address 2 mid-sweep
    for (int j = 0; j < 8; j++) write_word(3'(j), 4'(j));
    set_rd(3'd7, 3'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_val($sformatf("swp_busy_k%0d", k), 32'(busy), (k < 8) ? 32'h1 : 32'h0);
      check_val($sformatf("swp_rd7_k%0d", k), 32'(datOutR[3:0]), (k <= 8) ? 32'h7 : 32'h0);
      check_val($sformatf("swp_rd2_k%0d", k), 32'(datOutR[7:4]), (k <= 3) ? 32'h2 : 32'h0);
      check_val($sformatf("swp_wrdrop_k%0d", k), 32'(wr_drop), (k == 3) ? 32'h1 : 32'h0);
      if (k == 2) begin
        addrW = 3'd2; datW = 4'hA; RegWrite = 1'b1;
      end else begin
        RegWrite = 1'b0;
      end
      if (k < 9) tick();
    end
    RegWrite = 1'b0;

    // clr and RegWrite together in IDLE
`ifdef BANCO_BYPASS_EN
    expSim = 4'hC;
`else
    expSim = 4'h0;
`endif
    set_rd(3'd3, 3'd3);
    addrW = 3'd3; datW = 4'hC; RegWrite = 1'b1; clr = 1'b1;
    tick();
    RegWrite = 1'b0; clr = 1'b0;
    check_val("sim_busy", 32'(busy), 32'h1);
    check_val("sim_rd_edge0", 32'(datOutR[3:0]), 32'(expSim));
    tick();
    check_val("sim_rd_edge1", 32'(datOutR[3:0]), 32'hC);
    check_val("sim_wrdrop", 32'(wr_drop), 32'h0);
    for (int k = 0; k < 8; k++) tick();
    check_val("sim_end_busy", 32'(busy), 32'h0);
    check_val("sim_end_rd0", 32'(datOutR[3:0]), 32'h0);
    check_val("sim_end_rd1", 32'(datOutR[7:4]), 32'h0);

    // Reset in the middle of a sweep
    for (int j = 0; j < 8; j++) write_word(3'(j), 4'(j | 8));
    set_rd(3'd6, 3'd7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    check_val("mid_pre_busy", 32'(busy), 32'h1);
    check_val("mid_pre_rd6", 32'(datOutR[3:0]), 32'hE);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'h0);
    check_val("mid_rst_rd0", 32'(datOutR[3:0]), 32'h0);
    check_val("mid_rst_rd1", 32'(datOutR[7:4]), 32'h0);
    check_val("mid_rst_wrdrop", 32'(wr_drop), 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_rd(3'(i), 3'(i + 4));
      tick();
      check_val($sformatf("mid_mem%0d", i), 32'(datOutR[3:0]), 32'h0);
      check_val($sformatf("mid_mem%0d", i + 4), 32'(datOutR[7:4]), 32'h0);
    end
    set_rd(3'd1, 3'd1);
    write_word(3'd1, 4'h6);
    check_val("post_busy", 32'(busy), 32'h0);
    tick();
    check_val("post_wrdrop", 32'(wr_drop), 32'h0);
    check_val("post_rd0", 32'(datOutR[3:0]), 32'h6);
    check_val("post_rd1", 32'(datOutR[7:4]), 32'h6);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
